// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit ALU: valid/ready request capture, single-cycle ALU ops,
// an 8-cycle shift-add multiply on the shared adder, and registered results held under backpressure.
module alu_issue_ctrl #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_res,
  output logic               out_c,
  output logic               out_z,
  output logic               out_n,
  output logic               out_v,
  output logic               out_err,
  output logic               busy
);

  generate
    if (WIDTH != 8) begin : g_bad_width
      $error("alu_issue_ctrl supports WIDTH=8 only");
    end
  endgenerate

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               cin_q;
  logic [2:0]         count_q;
  logic [WIDTH-1:0]   acc_hi_q, mplier_q;
  logic [2*WIDTH-1:0] res_q;
  logic               c_q, z_q, n_q, v_q, err_q, valid_q;

  logic [WIDTH-1:0]   add_x, add_y;
  logic               add_ci;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   ex_res;
  logic               ex_c, ex_v, ex_err;
  logic [2*WIDTH-1:0] prod;

  // One adder serves ADD/SUB in EXEC and the partial-product accumulate in MUL.
  always_comb begin
    add_x  = a_q;
    add_y  = b_q;
    add_ci = 1'b0;
    if (state_q == S_MUL) begin
      add_x = acc_hi_q;
      add_y = mplier_q[0] ? a_q : '0;
    end else if (op_q == OP_SUB) begin
      add_y  = ~b_q;
      add_ci = 1'b1;
    end else if (op_q == OP_ADD) begin
      add_ci = cin_q;
    end
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
  end

  always_comb begin
    ex_res = '0;
    ex_c   = 1'b0;
    ex_v   = 1'b0;
    ex_err = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        ex_res = add_sum[WIDTH-1:0];
        ex_c   = add_sum[WIDTH];
        // add_y is already inverted for SUB, so one overflow rule covers both
        ex_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);
      end
      OP_AND:  ex_res = a_q & b_q;
      OP_OR:   ex_res = a_q | b_q;
      OP_XOR:  ex_res = a_q ^ b_q;
      OP_NOT:  ex_res = ~a_q;
      default: ex_err = 1'b1;
    endcase
  end

  // Product as it stands after this cycle's add and shift.
  assign prod = {add_sum, mplier_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      count_q  <= '0;
      acc_hi_q <= '0;
      mplier_q <= '0;
      res_q    <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= in_op;
            a_q   <= in_a;
            b_q   <= in_b;
            cin_q <= in_cin;
            if (in_op == OP_MUL && MUL_EN) begin
              state_q  <= S_MUL;
              count_q  <= '0;
              acc_hi_q <= '0;
              mplier_q <= in_b;
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          res_q   <= {{WIDTH{1'b0}}, ex_res};
          c_q     <= ex_c;
          z_q     <= (ex_res == '0);
          n_q     <= ex_res[WIDTH-1];
          v_q     <= ex_v;
          err_q   <= ex_err;
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_MUL: begin
          acc_hi_q <= add_sum[WIDTH:1];
          mplier_q <= {add_sum[0], mplier_q[WIDTH-1:1]};
          count_q  <= count_q + 3'd1;
          if (count_q == 3'd7) begin
            res_q   <= prod;
            c_q     <= (prod[2*WIDTH-1:WIDTH] != '0);
            z_q     <= (prod == '0);
            n_q     <= prod[2*WIDTH-1];
            v_q     <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = valid_q;
  assign out_res   = res_q;
  assign out_c     = c_q;
  assign out_z     = z_q;
  assign out_n     = n_q;
  assign out_v     = v_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl: two instances (MUL enabled / disabled) checked
// against an arithmetic reference model, including latency, backpressure and async reset.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  in_op;
  logic [7:0]  in_a, in_b;
  logic        in_cin;
  logic        iv[2], orr[2];
  logic        ir[2], ov[2], oc[2], oz[2], on[2], ovf[2], oe[2], bz[2];
  logic [15:0] ores[2];

  int total = 0;
  int bad   = 0;

  alu_issue_ctrl #(.WIDTH(8), .MUL_EN(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(ov[0]), .out_ready(orr[0]),
    .out_res(ores[0]), .out_c(oc[0]), .out_z(oz[0]), .out_n(on[0]), .out_v(ovf[0]),
    .out_err(oe[0]), .busy(bz[0]));

  alu_issue_ctrl #(.WIDTH(8), .MUL_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(ov[1]), .out_ready(orr[1]),
    .out_res(ores[1]), .out_c(oc[1]), .out_z(oz[1]), .out_n(on[1]), .out_v(ovf[1]),
    .out_err(oe[1]), .busy(bz[1]));

  typedef struct packed {
    logic [15:0] res;
    logic        c, z, n, v, err;
  } exp_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input bit mul_en, input logic [2:0] op,
                                 input logic [7:0] a, input logic [7:0] b, input logic cin);
    exp_t e;
    int ua, ub, sa, sb, r;
    e  = '0;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      3'd0: begin
        r     = ua + ub + int'(cin);
        e.res = 16'(r % 256);
        e.c   = (r > 255);
        e.v   = (sa + sb + int'(cin) > 127) || (sa + sb + int'(cin) < -128);
      end
      3'd1: begin
        e.res = 16'((ua - ub + 256) % 256);
        e.c   = (ua >= ub);
        e.v   = (sa - sb > 127) || (sa - sb < -128);
      end
      3'd2: e.res = {8'h00, a & b};
      3'd3: e.res = {8'h00, a | b};
      3'd4: e.res = {8'h00, a ^ b};
      3'd5: e.res = {8'h00, ~a};
      3'd6: begin
        if (mul_en) begin
          r     = ua * ub;
          e.res = 16'(r);
          e.c   = (r > 255);
        end else begin
          e.err = 1'b1;
        end
      end
      default: e.err = 1'b1;
    endcase
    e.z = (e.res == 16'h0000);
    if (op == 3'd6 && mul_en) e.n = (e.res >= 16'h8000);
    else                      e.n = e.res[7];
    return e;
  endfunction

  // Called at a falling edge with the selected instance idle.
  task automatic run_op(input int s, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic cin, input int hold);
    exp_t e;
    int   edges;
    int   exp_lat;
    e       = model(s == 0, op, a, b, cin);
    exp_lat = (op == 3'd6 && s == 0) ? 8 : 1;
    check_eq("idle_ready", ir[s], 1);
    in_op = op; in_a = a; in_b = b; in_cin = cin;
    iv[s] = 1'b1; orr[s] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[s] = 1'b0;
    in_op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
    check_eq("busy_after_accept", bz[s], 1);
    check_eq("ready_after_accept", ir[s], 0);
    edges = 0;
    while (ov[s] !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check_eq("latency", edges, exp_lat);
    check_eq("res", ores[s], e.res);
    check_eq("flags_czvne", {oc[s], oz[s], on[s], ovf[s], oe[s]}, {e.c, e.z, e.n, e.v, e.err});
    for (int i = 0; i < hold; i++) begin
      iv[s] = 1'b1;
      in_op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      @(negedge clk);
      check_eq("hold_valid", ov[s], 1);
      check_eq("hold_ready", ir[s], 0);
      check_eq("hold_res", ores[s], e.res);
      check_eq("hold_flags", {oc[s], oz[s], on[s], ovf[s], oe[s]}, {e.c, e.z, e.n, e.v, e.err});
    end
    iv[s] = 1'b0;
    orr[s] = 1'b1;
    @(negedge clk);
    check_eq("drain_valid", ov[s], 0);
    check_eq("drain_ready", ir[s], 1);
    orr[s] = 1'b0;
    $display("op dut%0d op=%0d a=%h b=%h cin=%0d res=%h lat=%0d hold=%0d", s, op, a, b, cin,
             e.res, exp_lat, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    iv[0] = 1'b0; iv[1] = 1'b0; orr[0] = 1'b0; orr[1] = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_cin = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", ir[0], 1);
    check_eq("rst_valid", ov[0], 0);
    check_eq("rst_busy", bz[0], 0);
    check_eq("rst_res", ores[0], 0);
    check_eq("rst_flags", {oc[0], oz[0], on[0], ovf[0], oe[0]}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 3'd0, 8'hFF, 8'h01, 1'b0, 0);
    run_op(0, 3'd0, 8'h7F, 8'h01, 1'b0, 1);
    run_op(0, 3'd1, 8'h05, 8'h07, 1'b0, 0);
    run_op(0, 3'd1, 8'h80, 8'h01, 1'b0, 0);
    run_op(0, 3'd6, 8'hFF, 8'hFF, 1'b0, 0);
    run_op(0, 3'd6, 8'h00, 8'h37, 1'b0, 0);
    run_op(0, 3'd4, 8'hAA, 8'h0F, 1'b0, 5);

    // Reset in the middle of a multiply, with count at 4.
    in_op = 3'd6; in_a = 8'h5A; in_b = 8'hC3; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mul_busy_pre_rst", bz[0], 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", ov[0], 0);
    check_eq("async_rst_ready", ir[0], 1);
    check_eq("async_rst_busy", bz[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_valid", ov[0], 0);
    run_op(0, 3'd0, 8'h03, 8'h04, 1'b0, 0);

    run_op(0, 3'd7, 8'h12, 8'h34, 1'b1, 0);
    run_op(0, 3'd2, 8'hF0, 8'h3C, 1'b0, 0);
    run_op(1, 3'd6, 8'h12, 8'h34, 1'b0, 0);
    run_op(1, 3'd2, 8'hF0, 8'h3C, 1'b0, 0);
    run_op(0, 3'd0, 8'h80, 8'h80, 1'b1, 0);
    run_op(0, 3'd5, 8'hFF, 8'h00, 1'b0, 0);

    for (int k = 0; k < 80; k++) begin
      run_op((($urandom % 4) == 0) ? 1 : 0, 3'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential front end for the 8-bit ALU datapath: accepts one operation request per handshake, latches operands and opcode, and drives the 8-bit adder/subtractor/logic components.
- Runs a multi-cycle shift-add multiply on top of the 8-bit adder.
- Registers the result and flags, and holds them under output backpressure.
- Sits between the instruction/register-file side (upstream) and the writeback consumer (downstream).

Parameters:
WIDTH, 8, operand width; only 8 is supported, and elaboration must fail otherwise.
MUL_EN, 1, 1 enables opcode MUL; 0 treats MUL as a reserved opcode.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  controller can accept a request
in_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT(a), 110 MUL, 111 reserved
in_a  input  8  operand A
in_b  input  8  operand B
in_cin  input  1  carry-in, used by ADD only
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_res  output  16  result; [15:8] is 0 for all ops except MUL
out_c  output  1  carry flag
out_z  output  1  zero flag
out_n  output  1  negative flag
out_v  output  1  signed overflow flag
out_err  output  1  reserved opcode flag
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; out_res=0; all flags=0; busy=0; MUL counter=0. Asserting reset mid-operation aborts the operation immediately, and no result is produced.
- States are IDLE, EXEC, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture op, a, b and cin.
  - If op is MUL and MUL_EN=1, go to MUL with count=0. Otherwise go to EXEC.
- EXEC (one cycle), computed from the captured operands:
  - ADD: {c,res[7:0]} = a+b+cin. v = signed overflow of that sum.
  - SUB: res = a+~b+1. c = carry out, so c=1 when a>=b unsigned. v = signed overflow of a-b.
  - AND/OR/XOR/NOT: bitwise result; c=0, v=0.
  - Reserved opcode: res=0, err=1, c=v=0.
  - All ops: z = (res[15:0]==0); n = res[7].
  - At the next edge, register the result and flags, set out_valid=1, and go to DONE.
- MUL (8 cycles):
  - Unsigned 8x8 shift-add using one 8-bit add per cycle.
  - The accumulator is {acc_hi[7:0], mplier[7:0]}, with a 1-bit carry held above acc_hi.
  - Each cycle: if mplier[0]=1, acc_hi += a. Then shift {carry, acc_hi, mplier} right by 1.
  - count increments on each of the 8 cycles. On the edge where count==7 the product is final; register it, set out_valid=1, and go to DONE.
  - Flags for MUL: c = (res[15:8]!=0); z = (res==0); n = res[15]; v=0.
- Latency, with the request accepted at edge k:
  - Single-cycle ops: out_valid is high after edge k+1.
  - MUL: out_valid is high after edge k+8.
- DONE:
  - out_valid=1, and out_res and all flags are held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1: out_valid goes to 0, then IDLE. Outputs retain their last values but are meaningless while out_valid=0.
- in_ready is 1 only in IDLE, so an accepted-to-accepted interval is at least 3 cycles (single op with out_ready tied high).
- in_valid while not IDLE is ignored and the request is not captured. The upstream block must hold it until in_ready.
- Input changes after capture do not affect the operation in flight.
- out_err is cleared by the next non-reserved op.

Test Plan:
1. ADD a=0xFF, b=0x01, cin=0 -> after 2 edges out_valid=1, res=0x0000, c=1, z=1, n=0, v=0. Then ADD 0x7F+0x01 -> res=0x0080, n=1, v=1, c=0.
2. SUB a=0x05, b=0x07 -> res=0x00FE, c=0 (borrow), n=1, v=0. Then SUB 0x80-0x01 -> res=0x007F, c=1, v=1.
3. MUL a=0xFF, b=0xFF -> out_valid exactly 8 edges after accept, res=0xFE01, c=1, n=1, z=0. Then MUL 0x00 x 0x37 -> res=0, z=1, c=0.
4. Backpressure: XOR 0xAA^0x0F with out_ready=0 for 5 cycles -> res=0x00A5 held stable with out_valid=1 and in_ready=0; a second in_valid is not captured. Raising out_ready -> IDLE on the next edge.
5. Reset mid-MUL at count=4 -> out_valid=0, in_ready=1 asynchronously, busy=0. After release, ADD 3+4 -> res=7 with normal latency.
6. Opcode 111 -> res=0, err=1, z=1. With MUL_EN=0, opcode 110 -> err=1, 1-cycle latency. The following AND 0xF0&0x3C -> res=0x0030, err=0.
